alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised execute-stage unit that merges ALU-control decode and the datapath. It takes `{funct7,funct3}` plus `aluOp`, registers the result, and runs MUL as an iterative multi-cycle operation behind a valid/ready handshake. It sits between the ID/EX pipeline register and EX/MEM. Its `ready_o` is the hazard unit's stall source, and `flush_i` lets branch resolution kill work in flight.

## Interface
- `XLEN`, 32: operand/result width; must be ≥ 8 and a power of two.
- `SHAMT_W`, `$clog2(XLEN)`: shift-amount bits taken from `b_i`.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  operation offered.
- `ready_o`  out  1  unit accepts an operation this cycle.
- `funct_i`  in  10  `{funct7, funct3}`.
- `aluOp_i`  in  2  00 load/store, 01 I-type, 10 R-type, 11 branch.
- `a_i`, `b_i`  in  XLEN  operands (b = immediate for 00/01).
- `flush_i`  in  1  synchronous abort.
- `valid_o`  out  1  result held.
- `ready_i`  in  1  downstream consumes result.
- `result_o`  out  XLEN  registered result.
- `zero_o`  out  1  `result_o == 0`, registered with it.
- `illegal_o`  out  1  undecodable funct; result is 0.
- `busy_o`  out  1  multiplier iterating.

## Operation
- Decode for aluOp 00 is ADD. aluOp 11 is SUB; `zero_o` gives the BEQ outcome.
- Decode for aluOp 10 uses the full 10-bit funct:
  - AND `0000000111`, OR `0000000110`, ADD `0000000000`, SUB `0100000000`, MUL `0000001000`
  - XOR `0000000100`, SLL `0000000001`, SRL `0000000101`, SRA `0100000101`, SLT `0000000010`
  - Anything else is illegal.
- Decode for aluOp 01 uses funct3 only: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL. For 101, `funct_i[8]` selects SRA (1) or SRL (0).
- Arithmetic is modulo 2^XLEN.
  - SLT is a signed compare and yields 1 or 0.
  - Shifts use `b_i[SHAMT_W-1:0]`.
  - MUL returns the low XLEN bits of the product; signed and unsigned give identical low bits.
- FSM states and transitions:
  - IDLE: accept when `valid_i && ready_o`. Non-MUL ops load the output register directly and stay in IDLE. MUL loads the multiplier and goes to MUL.
  - MUL: radix-2 shift-add for exactly XLEN cycles, using a counter of `$clog2(XLEN)+1` bits. On the last cycle, go to DONE.
  - DONE: load the product into the output register and return to IDLE.
- `ready_o = (state==IDLE) && (!valid_o || ready_i) && rst_i`. This gives back-to-back single-cycle ops at full rate.
- Output register holds `result_o`, `zero_o` and `illegal_o` stable while `valid_o && !ready_i`.
- `flush_i` has priority over every event in the same cycle:
  - state goes to IDLE, counter is cleared, `valid_o` goes to 0;
  - any operation offered that cycle is not accepted (`ready_o` is forced to 0).
- `ready_i` is ignored while `valid_o = 0`.

## Timing
- Reset state (asynchronous): `valid_o`, `result_o`, `zero_o`, `illegal_o`, `busy_o` all 0; state is IDLE; `ready_o` is 0 while `rst_i` is low.
- Reset during MUL aborts the operation; no result is produced after release.
- Latency for a non-MUL op accepted at edge N: `valid_o` is high after edge N.
- Latency for a MUL accepted at edge N:
  - `busy_o` is high after edges N … N+XLEN−1;
  - `valid_o` is high after edge N+XLEN+1;
  - `ready_o` is low throughout.
- If the output register is still occupied when DONE is reached, DONE holds until `ready_i`. No result is dropped.
- Simultaneous consume and accept (`valid_o && ready_i && valid_i` in IDLE) replaces the output in that same edge.

## Structure
- `alu_exec_pkg` holds:
  - `alu_op_e` enum (AND, OR, ADD, SUB, MUL, XOR, SLL, SRL, SRA, SLT);
  - `localparam`s for the ten funct encodings and the four aluOp codes;
  - the state enum (IDLE, MUL, DONE).
- Decode is a combinational function in the package.
- Sub-module `alu_exec_mul`, parametrised on XLEN, holds the multiplicand/multiplier/accumulator registers, the counter, and `start`/`done`/`abort` pins.

## Test plan
- R-type ADD `a=7, b=5`, `ready_i=1` → `result_o=12`, `zero_o=0`, `valid_o` one cycle after accept.
- Branch aluOp 11 `a=b=0x1234` → `result_o=0`, `zero_o=1`. Then R-type funct `0000000011` → `illegal_o=1`, `result_o=0`.
- MUL `a=0xFFFFFFFF, b=3`, XLEN=32 → `result_o=0xFFFFFFFD` after 33 cycles; `busy_o` high for 32 cycles; `ready_o` low until the result is consumed.
- Back-to-back SRA `a=0x80000000, b=4` then SLT `a=-1, b=1`, with `ready_i` low for 3 cycles:
  - first result `0xF8000000` held stable;
  - second op not accepted until drained;
  - second result is 1.
- `flush_i` at cycle 10 of a MUL → `valid_o` never rises, `ready_o=1` next cycle, and a following ADD `2+2=4` completes normally.
- `rst_i` low mid-MUL → all outputs 0 immediately (asynchronous); no stale result after release.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types, encodings and the combinational decode for the execute-stage ALU.
package alu_exec_pkg;

    localparam int unsigned FUNCT_W = 10;
    localparam int unsigned ALUOP_W = 2;

    typedef enum logic [3:0] {
        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL,
        OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_e;

    typedef struct packed {
        alu_op_e op;
        logic    illegal;
    } alu_dec_t;

    localparam logic [ALUOP_W-1:0] ALUOP_LDST   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_ITYPE  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b11;

    localparam logic [FUNCT_W-1:0] FUNCT_AND = 10'b0000000111;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 10'b0000000110;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 10'b0000000000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 10'b0100000000;
    localparam logic [FUNCT_W-1:0] FUNCT_MUL = 10'b0000001000;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR = 10'b0000000100;
    localparam logic [FUNCT_W-1:0] FUNCT_SLL = 10'b0000000001;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL = 10'b0000000101;
    localparam logic [FUNCT_W-1:0] FUNCT_SRA = 10'b0100000101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 10'b0000000010;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SHR = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // I-type looks only at funct3; bit 8 (funct7[5]) picks arithmetic right shift.
    function automatic alu_dec_t alu_decode(input logic [ALUOP_W-1:0] alu_op,
                                            input logic [FUNCT_W-1:0] funct);
        alu_dec_t dec;
        dec.op      = OP_ADD;
        dec.illegal = 1'b0;
        case (alu_op)
            ALUOP_LDST:   dec.op = OP_ADD;
            ALUOP_BRANCH: dec.op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_AND: dec.op = OP_AND;
                    FUNCT_OR:  dec.op = OP_OR;
                    FUNCT_ADD: dec.op = OP_ADD;
                    FUNCT_SUB: dec.op = OP_SUB;
                    FUNCT_MUL: dec.op = OP_MUL;
                    FUNCT_XOR: dec.op = OP_XOR;
                    FUNCT_SLL: dec.op = OP_SLL;
                    FUNCT_SRL: dec.op = OP_SRL;
                    FUNCT_SRA: dec.op = OP_SRA;
                    FUNCT_SLT: dec.op = OP_SLT;
                    default:   dec.illegal = 1'b1;
                endcase
            end
            default: begin
                case (funct[2:0])
                    F3_ADD:  dec.op = OP_ADD;
                    F3_AND:  dec.op = OP_AND;
                    F3_OR:   dec.op = OP_OR;
                    F3_XOR:  dec.op = OP_XOR;
                    F3_SLT:  dec.op = OP_SLT;
                    F3_SLL:  dec.op = OP_SLL;
                    F3_SHR:  dec.op = funct[8] ? OP_SRA : OP_SRL;
                    default: dec.illegal = 1'b1;
                endcase
            end
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/alu_exec_mul.sv
// Iterative radix-2 shift-add multiplier returning the low XLEN bits of a*b.
module alu_exec_mul #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_c,
    output logic [XLEN-1:0] product_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // One multiplier bit per cycle; done_c flags the final iteration.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_c   = busy_q && (cnt_q == CNT_W'(XLEN - 1));
        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_d = 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign product_o = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decode + registered result, MUL iterated behind a valid/ready handshake.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [ALUOP_W-1:0] aluOp_i,
    input  logic [XLEN-1:0]    a_i,
    input  logic [XLEN-1:0]    b_i,
    input  logic               flush_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    result_o,
    output logic               zero_o,
    output logic               illegal_o,
    output logic               busy_o
);

    state_e          state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    alu_dec_t         dec_c;
    logic [XLEN-1:0]  alu_res_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic             out_free_c;
    logic             accept_c;
    logic             mul_start_c;
    logic             mul_done_c;
    logic [XLEN-1:0]  mul_product;

    assign dec_c       = alu_decode(aluOp_i, funct_i);
    assign shamt_c     = b_i[SHAMT_W-1:0];
    assign out_free_c  = !valid_q || ready_i;
    assign ready_o     = (state_q == ST_IDLE) && out_free_c && rst_i && !flush_i;
    assign accept_c    = valid_i && ready_o;
    assign mul_start_c = accept_c && !dec_c.illegal && (dec_c.op == OP_MUL);

    alu_exec_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start_c),
        .abort_i   (flush_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_c    (mul_done_c),
        .product_o (mul_product)
    );

    // Single-cycle datapath; illegal decodes force a zero result.
    always_comb begin
        alu_res_c = '0;
        case (dec_c.op)
            OP_AND:  alu_res_c = a_i & b_i;
            OP_OR:   alu_res_c = a_i | b_i;
            OP_ADD:  alu_res_c = a_i + b_i;
            OP_SUB:  alu_res_c = a_i - b_i;
            OP_XOR:  alu_res_c = a_i ^ b_i;
            OP_SLL:  alu_res_c = a_i << shamt_c;
            OP_SRL:  alu_res_c = a_i >> shamt_c;
            OP_SRA:  alu_res_c = XLEN'($signed(a_i) >>> shamt_c);
            OP_SLT:  alu_res_c = XLEN'($signed(a_i) < $signed(b_i));
            default: alu_res_c = '0;
        endcase
        if (dec_c.illegal) begin
            alu_res_c = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Flush wins over everything; a consume and a new load may share one edge.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (mul_start_c) begin
                        state_d = ST_MUL;
                    end else if (accept_c) begin
                        valid_d   = 1'b1;
                        result_d  = alu_res_c;
                        zero_d    = (alu_res_c == '0);
                        illegal_d = dec_c.illegal;
                    end
                end
                ST_MUL: begin
                    if (mul_done_c) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_free_c) begin
                        state_d   = ST_IDLE;
                        valid_d   = 1'b1;
                        result_d  = mul_product;
                        zero_d    = (mul_product == '0);
                        illegal_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed table, handshake corner sequences, random vs. model.
module tb_alu_exec_unit;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [9:0]      funct_i = '0;
    logic [1:0]      aluOp_i = '0;
    logic [XLEN-1:0] a_i = '0;
    logic [XLEN-1:0] b_i = '0;
    logic            flush_i = 1'b0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            illegal_o;
    logic            busy_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]      op;
        logic [9:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        logic            ill;
        logic            mul;
    } vec_t;

    vec_t vecs[$];
    logic [9:0] rfun [10];

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .funct_i   (funct_i),
        .aluOp_i   (aluOp_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reference behaviour straight from the instruction rules, plain arithmetic.
    function automatic void ref_model(input logic [1:0] op, input logic [9:0] f,
                                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                      output logic [XLEN-1:0] res, output logic ill,
                                      output logic is_mul);
        int unsigned sh;
        logic signed [XLEN-1:0] sa, sb;
        sh = b % XLEN;
        sa = a;
        sb = b;
        res = '0;
        ill = 1'b0;
        is_mul = 1'b0;
        if (op == 2'b00) res = a + b;
        else if (op == 2'b11) res = a - b;
        else if (op == 2'b10) begin
            case (f)
                10'b0000000111: res = a & b;
                10'b0000000110: res = a | b;
                10'b0000000000: res = a + b;
                10'b0100000000: res = a - b;
                10'b0000001000: begin res = a * b; is_mul = 1'b1; end
                10'b0000000100: res = a ^ b;
                10'b0000000001: res = a << sh;
                10'b0000000101: res = a >> sh;
                10'b0100000101: res = sa >>> sh;
                10'b0000000010: res = (sa < sb) ? 1 : 0;
                default:        ill = 1'b1;
            endcase
        end else begin
            case (f[2:0])
                3'b000:  res = a + b;
                3'b111:  res = a & b;
                3'b110:  res = a | b;
                3'b100:  res = a ^ b;
                3'b010:  res = (sa < sb) ? 1 : 0;
                3'b001:  res = a << sh;
                3'b101:  res = f[8] ? XLEN'(sa >>> sh) : (a >> sh);
                default: ill = 1'b1;
            endcase
        end
    endfunction

    // Offer one op, track latency/busy, hold the result for 'stall' cycles, then drain.
    task automatic run_op(input string name, input logic [1:0] op, input logic [9:0] f,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] er, input logic eill, input logic emul,
                          input int stall);
        int waitc, lat, busyc, rdyhi;
        aluOp_i = op; funct_i = f; a_i = a; b_i = b;
        valid_i = 1'b1; ready_i = 1'b1;
        #1;
        waitc = 0;
        while (!ready_o && waitc < 50) begin tick; waitc++; end
        check({name, " accept"}, ready_o, 1);
        tick;
        valid_i = 1'b0; ready_i = 1'b0;
        #1;
        lat = 0; busyc = 0; rdyhi = 0;
        while (!valid_o && lat < 100) begin
            if (busy_o) busyc++;
            if (ready_o) rdyhi++;
            tick;
            lat++;
        end
        check({name, " latency"}, lat, emul ? XLEN + 1 : 0);
        check({name, " busy cycles"}, busyc, emul ? XLEN : 0);
        if (emul) check({name, " ready low in mul"}, rdyhi, 0);
        check({name, " result"}, {zero_o, illegal_o, result_o}, {(er == '0), eill, er});
        for (int i = 0; i < stall; i++) begin
            tick;
            check({name, " hold"}, {valid_o, ready_o, busy_o, result_o}, {1'b1, 1'b0, 1'b0, er});
        end
        ready_i = 1'b1;
        #1;
        check({name, " ready on drain"}, ready_o, 1);
        tick;
        check({name, " drained"}, valid_o, 0);
    endtask

    initial begin
        int cnt;
        logic [1:0] op;
        logic [9:0] f;
        logic [XLEN-1:0] a, b, er;
        logic eill, emul;

        rfun = '{10'b0000000111, 10'b0000000110, 10'b0000000000, 10'b0100000000,
                 10'b0000001000, 10'b0000000100, 10'b0000000001, 10'b0000000101,
                 10'b0100000101, 10'b0000000010};

        vecs.push_back(vec_t'{2'b10, 10'b0000000000, 32'd7,         32'd5,         32'd12,        1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b11, 10'b0000000000, 32'h1234,      32'h1234,      32'h0,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000011, 32'h55,        32'h22,        32'h0,         1'b1, 1'b0});
        vecs.push_back(vec_t'{2'b11, 10'b1111111111, 32'd5,         32'd3,         32'd2,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0100000000, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000111, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000110, 32'hF0F0F0F0,  32'hFF00FF00,  32'hFFF0FFF0,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000100, 32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000001, 32'd1,         32'd31,        32'h80000000,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000001, 32'd1,         32'd33,        32'd2,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000101, 32'h80000000,  32'd4,         32'h08000000,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0100000101, 32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000010, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000010, 32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000000000, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b01, 10'b1111111000, 32'd3,         32'd4,         32'd7,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b01, 10'b0000001000, 32'd6,         32'd7,         32'd13,        1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b01, 10'b0000000001, 32'd3,         32'h21,        32'd6,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b01, 10'b0000000101, 32'h80000000,  32'd4,         32'h08000000,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b01, 10'b0100000101, 32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b01, 10'b0000000010, 32'h7FFFFFFF,  32'h80000000,  32'd0,         1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b01, 10'b0000000011, 32'd9,         32'd9,         32'd0,         1'b1, 1'b0});
        vecs.push_back(vec_t'{2'b00, 10'b1111111111, 32'h100,       32'hFFFFFFFC,  32'hFC,        1'b0, 1'b0});
        vecs.push_back(vec_t'{2'b10, 10'b0000001000, 32'hFFFFFFFF,  32'd3,         32'hFFFFFFFD,  1'b0, 1'b1});
        vecs.push_back(vec_t'{2'b10, 10'b0000001000, 32'h12345678,  32'h10,        32'h23456780,  1'b0, 1'b1});

        // Asynchronous reset from power-up.
        #1 rst_i = 1'b0;
        #2;
        check("reset outputs", {valid_o, zero_o, illegal_o, busy_o, result_o}, '0);
        check("reset ready_o", ready_o, 0);
        repeat (2) tick;
        rst_i = 1'b1;
        tick;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].ill, vecs[i].mul, i % 3);
        end

        // Back-to-back: SRA held under backpressure, SLT waits, then consume+accept together.
        aluOp_i = 2'b10; funct_i = 10'b0100000101; a_i = 32'h80000000; b_i = 32'd4;
        valid_i = 1'b1; ready_i = 1'b1;
        #1;
        check("b2b sra ready", ready_o, 1);
        tick;
        funct_i = 10'b0000000010; a_i = 32'hFFFFFFFF; b_i = 32'd1; ready_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("b2b hold", {valid_o, ready_o, result_o}, {1'b1, 1'b0, 32'hF8000000});
            tick;
        end
        ready_i = 1'b1;
        #1;
        check("b2b ready after drain", ready_o, 1);
        tick;
        valid_i = 1'b0;
        check("b2b slt result", {valid_o, illegal_o, result_o}, {1'b1, 1'b0, 32'd1});
        tick;
        check("b2b slt drained", valid_o, 0);

        // Flush ten cycles into a MUL.
        aluOp_i = 2'b10; funct_i = 10'b0000001000; a_i = 32'd1234; b_i = 32'd99;
        valid_i = 1'b1; ready_i = 1'b1;
        #1;
        check("flush mul accept", ready_o, 1);
        tick;
        valid_i = 1'b0;
        repeat (9) tick;
        check("flush mul busy", busy_o, 1);
        flush_i = 1'b1;
        #1;
        check("flush ready forced low", ready_o, 0);
        tick;
        flush_i = 1'b0;
        #1;
        check("flush state", {busy_o, valid_o, ready_o}, {1'b0, 1'b0, 1'b1});
        cnt = 0;
        repeat (40) begin tick; if (valid_o || busy_o) cnt++; end
        check("flush no late result", cnt, 0);
        run_op("post-flush add", 2'b10, 10'b0000000000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 0);

        // Flush kills a pending result and blocks a same-cycle offer.
        aluOp_i = 2'b00; funct_i = '0; a_i = 32'd9; b_i = 32'd1; valid_i = 1'b1; ready_i = 1'b1;
        #1;
        tick;
        a_i = 32'd5; b_i = 32'd5; ready_i = 1'b1; flush_i = 1'b1;
        #1;
        check("flush vs offer ready", ready_o, 0);
        tick;
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        check("flush vs offer valid", {valid_o, result_o}, {1'b0, 32'd10});

        // Asynchronous reset in the middle of a MUL.
        aluOp_i = 2'b10; funct_i = 10'b0000001000; a_i = 32'd5; b_i = 32'd7;
        valid_i = 1'b1; ready_i = 1'b1;
        #1;
        tick;
        valid_i = 1'b0;
        repeat (5) tick;
        #2 rst_i = 1'b0;
        #1;
        check("midmul reset outputs", {valid_o, zero_o, illegal_o, busy_o, result_o}, '0);
        check("midmul reset ready", ready_o, 0);
        tick;
        #2 rst_i = 1'b1;
        cnt = 0;
        repeat (50) begin tick; if (valid_o || busy_o) cnt++; end
        check("no stale result after reset", cnt, 0);
        run_op("post-reset mul", 2'b10, 10'b0000001000, 32'd5, 32'd7, 32'd35, 1'b0, 1'b1, 1);

        // Random ops against the reference model.
        for (int n = 0; n < 120; n++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b10 && $urandom_range(0, 9) != 0) f = rfun[$urandom_range(0, 9)];
            else f = 10'($urandom);
            a = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 15)) : XLEN'($urandom);
            b = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 40)) : XLEN'($urandom);
            ref_model(op, f, a, b, er, eill, emul);
            run_op($sformatf("rand%0d op=%0d f=%0b a=%0h b=%0h", n, op, f, a, b),
                   op, f, a, b, er, eill, emul, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
